resampler_seq: RTL and testbench

Frame-level sequencer for the spectral resampler. It tracks the FFT bin stream into the resampler's bin RAM and back-pressures the FFT while a frame is being resampled. It latches a per-frame scale factor from a shadow register and launches the resample pass. It supervises completion with a watchdog and keeps frame and error statistics. It sits between the FFT core, the pitch-control register interface and the resampler.

---
 rtl/resampler_seq_pkg.sv | 33 +++
 rtl/resampler_seq_if.sv | 34 +++
 rtl/resampler_seq_sf_clamp.sv | 29 ++
 rtl/resampler_seq.sv | 139 +++++++++++++
 tb/tb_resampler_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/resampler_seq_pkg.sv
// Shared types and constants for the spectral resampler frame sequencer.
package resampler_pkg;

    localparam int unsigned N_BINS   = 4096;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned SF_W     = 24;
    localparam int unsigned PIPE_LAT = 5;
    localparam int unsigned WD_SLACK = 16;
    localparam int unsigned WD_LIMIT = N_BINS + PIPE_LAT + WD_SLACK;
    localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
    localparam int unsigned FRM_W    = 16;
    localparam int unsigned ERR_W    = 8;

    // Q3.21 scale factors
    localparam logic [SF_W-1:0] SF_ONE = 24'h200000;
    localparam logic [SF_W-1:0] SF_MIN = 24'h080000;
    localparam logic [SF_W-1:0] SF_MAX = 24'h800000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic logic [SF_W-1:0] sf_clamp_f(input logic [SF_W-1:0] sf);
        if (sf < SF_MIN)      return SF_MIN;
        else if (sf > SF_MAX) return SF_MAX;
        else                  return sf;
    endfunction

endpackage

// File: rtl/resampler_seq_if.sv
// FFT stream, pitch-control, resampler and statistics signals of the sequencer.
interface resampler_seq_if;
    import resampler_pkg::*;

    logic              s_fft_valid;
    logic              s_fft_last;
    logic [ADDR_W-1:0] s_fft_user;
    logic              s_fft_ready;
    logic              sf_wr;
    logic [SF_W-1:0]   sf_in;
    logic              dn_ready;
    logic              rs_valid;
    logic              rs_last;
    logic              m_start;
    logic [SF_W-1:0]   m_scale_factor;
    logic              m_scale_factor_valid;
    logic              busy;
    logic              frame_err;
    logic [FRM_W-1:0]  frames_done;
    logic [ERR_W-1:0]  err_count;

    modport slave (
        input  s_fft_valid, s_fft_last, s_fft_user, sf_wr, sf_in, dn_ready, rs_valid, rs_last,
        output s_fft_ready, m_start, m_scale_factor, m_scale_factor_valid, busy, frame_err,
               frames_done, err_count
    );

    modport master (
        output s_fft_valid, s_fft_last, s_fft_user, sf_wr, sf_in, dn_ready, rs_valid, rs_last,
        input  s_fft_ready, m_start, m_scale_factor, m_scale_factor_valid, busy, frame_err,
               frames_done, err_count
    );

endinterface

// File: rtl/resampler_seq_sf_clamp.sv
// Shadow scale-factor register and the clamped active copy loaded at frame launch.
module sf_clamp
    import resampler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sf_wr,
    input  logic [SF_W-1:0] i_sf_in,
    input  logic            i_load,
    output logic [SF_W-1:0] o_active
);

    logic [SF_W-1:0] r_shadow;
    logic [SF_W-1:0] r_active;

    // A write coinciding with a load lands in the shadow only; the load sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= SF_ONE;
            r_active <= SF_ONE;
        end else begin
            if (i_sf_wr) r_shadow <= i_sf_in;
            if (i_load)  r_active <= sf_clamp_f(r_shadow);
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/resampler_seq.sv
// Frame sequencer: tracks FFT bins into the bin RAM, launches the resample pass,
// supervises completion with a watchdog and keeps frame/error statistics.
module resampler_seq
    import resampler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    resampler_seq_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_err;
    logic              w_done;
    logic              w_launch;
    logic              w_accept;
    logic              w_rs_end;
    logic              w_last_idx;
    logic              w_wd_expire;

    logic              r_ready;
    logic              r_start;
    logic              r_sfv;
    logic              r_busy;
    logic              r_err;
    logic [FRM_W-1:0]  r_frames;
    logic [ERR_W-1:0]  r_errs;
    logic [ADDR_W-1:0] r_bin;
    logic [WD_W-1:0]   r_wd;
    logic [SF_W-1:0]   w_active_sf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_launch    = 1'b0;
        w_accept    = bus.s_fft_valid && r_ready;
        w_rs_end    = bus.rs_valid && bus.rs_last;
        w_last_idx  = (r_bin == ADDR_W'(N_BINS - 1));
        w_wd_expire = (r_wd == WD_W'(WD_LIMIT - 1));

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.s_fft_user != '0 || bus.s_fft_last) w_err  = 1'b1;
                    else                                        w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                // last must coincide exactly with the final bin index
                if (w_accept) begin
                    if (bus.s_fft_user != r_bin || bus.s_fft_last != w_last_idx) w_err  = 1'b1;
                    else if (bus.s_fft_last)                                      w_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.dn_ready) begin
                    w_launch = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.rs_valid) w_next = ST_DRAIN;
                if (w_wd_expire)  w_err  = 1'b1;
            end
            ST_DRAIN: begin
                if (w_rs_end) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_wd_expire) begin
                    w_err = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_rs_end && r_state != ST_DRAIN) w_err = 1'b1;

        if (w_err) begin
            w_next   = ST_IDLE;
            w_launch = 1'b0;
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready  <= 1'b1;
            r_start  <= 1'b0;
            r_sfv    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_frames <= '0;
            r_errs   <= '0;
            r_bin    <= '0;
            r_wd     <= '0;
        end else begin
            r_ready <= (w_next == ST_IDLE) || (w_next == ST_FILL);
            r_busy  <= !((w_next == ST_IDLE) || (w_next == ST_FILL));
            r_start <= w_launch;
            r_sfv   <= (w_next == ST_RUN) || (w_next == ST_DRAIN);
            r_err   <= w_err;

            if (w_done)                r_frames <= r_frames + FRM_W'(1);
            if (w_err && r_errs != '1) r_errs   <= r_errs + ERR_W'(1);

            // wraps back to zero after the final bin is accepted
            if (w_err)         r_bin <= '0;
            else if (w_accept) r_bin <= r_bin + ADDR_W'(1);

            if (w_launch)                                    r_wd <= '0;
            else if (r_state == ST_RUN || r_state == ST_DRAIN) r_wd <= r_wd + WD_W'(1);
        end
    end

    sf_clamp u_sf_clamp (
        .clk      (clk),
        .rst      (rst),
        .i_sf_wr  (bus.sf_wr),
        .i_sf_in  (bus.sf_in),
        .i_load   (w_launch),
        .o_active (w_active_sf)
    );

    assign bus.s_fft_ready          = r_ready;
    assign bus.m_start              = r_start;
    assign bus.m_scale_factor       = w_active_sf;
    assign bus.m_scale_factor_valid = r_sfv;
    assign bus.busy                 = r_busy;
    assign bus.frame_err            = r_err;
    assign bus.frames_done          = r_frames;
    assign bus.err_count            = r_errs;

endmodule

// File: tb/tb_resampler_seq.sv
// Scoreboard bench for resampler_seq: stimulus pushes expected launch/error/done events,
// a negedge monitor pops and compares them as the sequencer reports them.
module tb_resampler_seq;
    import resampler_pkg::*;

    localparam int NB = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    resampler_seq_if bus();

    resampler_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          kind;   // 0 launch, 1 error, 2 frame done
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_errs   = 0;

    // behavioural reference state
    int          m_exp    = 0;
    int          m_err    = 0;
    int          m_frames = 0;
    logic [23:0] m_shadow = 24'h200000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_clamp(input logic [23:0] v);
        if (v < 24'h080000) return 24'h080000;
        if (v > 24'h800000) return 24'h800000;
        return v;
    endfunction

    function automatic void push_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic pop_ev(input int kind, input logic [31:0] act, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL %s: unexpected event, value %0h, none required", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== act) begin
                n_errs++;
                $display("FAIL %s: got event %0d value %0h, required event %0d value %0h",
                         name, kind, act, e.kind, e.val);
            end
        end
    endtask

    // Monitor: compares every launch, error pulse and frame completion against the queue.
    initial begin
        logic [15:0] prev_fd = '0;
        bit          resync  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                resync = 1'b1;
            end else begin
                if (resync) begin
                    prev_fd = bus.frames_done;
                    resync  = 1'b0;
                end
                if (bus.m_start)   pop_ev(0, 32'(bus.m_scale_factor), "launch_scale");
                if (bus.frame_err) pop_ev(1, 32'(bus.err_count), "error_count");
                if (bus.frames_done != prev_fd) begin
                    pop_ev(2, 32'(bus.frames_done), "frames_done");
                    prev_fd = bus.frames_done;
                end
            end
        end
    end

    // Reference: a frame is bins 0..NB-1 in order with last exactly on the final bin.
    task automatic model_beat(input int user, input bit last);
        bit bad;
        bad = (user != m_exp) || (last && m_exp != NB - 1) || (!last && m_exp == NB - 1);
        if (bad) begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
            push_ev(1, 32'(m_err));
            m_exp = 0;
        end else if (last) begin
            m_exp = 0;
        end else begin
            m_exp++;
        end
    endtask

    task automatic send_beat(input int user, input bit last);
        int w = 0;
        if ($urandom_range(15) == 0) tick();
        while (!bus.s_fft_ready && w < 20) begin
            tick();
            w++;
        end
        if (!bus.s_fft_ready) chk("ready_wait", 32'(bus.s_fft_ready), 32'd1);
        bus.s_fft_valid = 1'b1;
        bus.s_fft_user  = 12'(user);
        bus.s_fft_last  = last;
        model_beat(user, last);
        tick();
        bus.s_fft_valid = 1'b0;
        bus.s_fft_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < NB; i++) send_beat(i, i == NB - 1);
        chk("ready_low_armed", 32'(bus.s_fft_ready), 32'd0);
        chk("busy_armed", 32'(bus.busy), 32'd1);
    endtask

    task automatic sf_write(input logic [23:0] v);
        bus.sf_wr = 1'b1;
        bus.sf_in = v;
        m_shadow  = v;
        tick();
        bus.sf_wr = 1'b0;
    endtask

    task automatic launch(input bit wr, input logic [23:0] v);
        repeat ($urandom_range(3)) tick();
        push_ev(0, 32'(ref_clamp(m_shadow)));
        bus.dn_ready = 1'b1;
        if (wr) begin
            bus.sf_wr = 1'b1;
            bus.sf_in = v;
            m_shadow  = v;
        end
        tick();
        bus.sf_wr    = 1'b0;
        bus.dn_ready = 1'b0;
        chk("start_after_dn_ready", 32'(bus.m_start), 32'd1);
    endtask

    // Resampler model: output beats begin PIPE_LAT cycles after the launch pulse.
    task automatic respond(input int n, input bit with_last, input bit mid_wr);
        repeat (PIPE_LAT - 1) tick();
        if (with_last) begin
            m_frames++;
            push_ev(2, 32'(m_frames));
        end
        for (int i = 0; i < n; i++) begin
            bus.rs_valid = 1'b1;
            bus.rs_last  = with_last && (i == n - 1);
            if (mid_wr && i == 10) begin
                bus.sf_wr = 1'b1;
                bus.sf_in = 24'h400000;
                m_shadow  = 24'h400000;
            end
            tick();
            bus.sf_wr = 1'b0;
            if (i == n / 2) begin
                chk("ready_low_drain", 32'(bus.s_fft_ready), 32'd0);
                chk("sfv_drain", 32'(bus.m_scale_factor_valid), 32'd1);
            end
        end
        bus.rs_valid = 1'b0;
        bus.rs_last  = 1'b0;
        if (with_last) begin
            chk("ready_after_last", 32'(bus.s_fft_ready), 32'd1);
            chk("sfv_after_last", 32'(bus.m_scale_factor_valid), 32'd0);
            chk("busy_after_last", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.s_fft_ready), 32'd1);
        chk({tag, "_start"}, 32'(bus.m_start), 32'd0);
        chk({tag, "_scale"}, 32'(bus.m_scale_factor), 32'h200000);
        chk({tag, "_sfv"}, 32'(bus.m_scale_factor_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.frame_err), 32'd0);
        chk({tag, "_frames"}, 32'(bus.frames_done), 32'd0);
        chk({tag, "_errcnt"}, 32'(bus.err_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.s_fft_valid = 1'b0;
        bus.s_fft_last  = 1'b0;
        bus.s_fft_user  = '0;
        bus.sf_wr       = 1'b0;
        bus.sf_in       = '0;
        bus.dn_ready    = 1'b0;
        bus.rs_valid    = 1'b0;
        bus.rs_last     = 1'b0;
        rst             = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("rst");

        // nominal frame
        sf_write(24'h300000);
        send_frame();
        launch(1'b0, '0);
        respond(NB, 1'b1, 1'b0);

        // early last, out-of-order bin, bad first bin
        for (int i = 0; i <= 100; i++) send_beat(i, i == 100);
        chk("ready_after_err", 32'(bus.s_fft_ready), 32'd1);
        chk("busy_after_err", 32'(bus.busy), 32'd0);
        send_beat(0, 1'b0);
        send_beat(5, 1'b0);
        send_beat(7, 1'b0);

        // clamp low, then clamp high with a write during the resample pass
        sf_write(24'h000000);
        send_frame();
        launch(1'b0, '0);
        respond(NB, 1'b1, 1'b0);

        sf_write(24'hFFFFFF);
        send_frame();
        launch(1'b0, '0);
        respond(NB, 1'b1, 1'b1);
        chk("scale_held_after_mid_write", 32'(bus.m_scale_factor), 32'h800000);

        // watchdog: resampler never answers
        send_frame();
        launch(1'b0, '0);
        m_err = m_err + 1;
        push_ev(1, 32'(m_err));
        k = 0;
        while (!bus.frame_err && k < 5000) begin
            tick();
            k++;
        end
        chk("watchdog_latency", 32'(k), 32'(WD_LIMIT));
        chk("watchdog_sfv", 32'(bus.m_scale_factor_valid), 32'd0);
        chk("watchdog_ready", 32'(bus.s_fft_ready), 32'd1);

        // launch with a simultaneous shadow write, then reset during DRAIN
        send_frame();
        launch(1'b1, 24'h100000);
        respond(20, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_reset_values("mid_rst");
        rst      = 1'b0;
        m_shadow = 24'h200000;
        m_frames = 0;
        m_err    = 0;
        m_exp    = 0;
        tick();
        tick();
        chk("events_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
